spi_mosi_tx: RTL and testbench

// Master-side SPI transmitter, the send path paired with the SPI byte receiver on the MISO line.

---
 rtl/spi_mosi_tx_if.sv | 35 +++
 rtl/spi_mosi_tx.sv | 199 +++++++++++++++++++
 tb/tb_spi_mosi_tx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mosi_tx_if.sv
// -----------------------------------------------------------------------------
// spi_mosi_tx_if
// Groups the word handshake and the SPI pin outputs of the MOSI transmitter.
//   tx_data      word to send, sampled only on handshake
//   tx_valid     tx_data valid, held until accepted
//   tx_ready     transmitter can accept a word
//   spi_cs       chip select, active low
//   spi_sclk     SPI serial clock, idle low (mode 0)
//   spi_mosi_out serial data out
//   busy         frame in progress
//   done         one-cycle pulse when spi_cs deasserts at normal frame end
// Modports: master = word producer / pin observer, slave = transmitter.
// -----------------------------------------------------------------------------
interface spi_mosi_tx_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             spi_cs;
  logic             spi_sclk;
  logic             spi_mosi_out;
  logic             busy;
  logic             done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, spi_cs, spi_sclk, spi_mosi_out, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, spi_cs, spi_sclk, spi_mosi_out, busy, done
  );
endinterface

// File: rtl/spi_mosi_tx.sv
// -----------------------------------------------------------------------------
// spi_mosi_tx
// Master-side SPI mode-0 transmitter. Accepts one DSIZE-bit word per valid/ready
// handshake, drops spi_cs, generates spi_sclk by dividing spi_clk by CLK_DIV per
// half-period, shifts the word out on spi_mosi_out and releases spi_cs after a
// trailing half-period. spi_cs then stays high for CS_GAP cycles before the next
// word can be accepted.
// Ports:
//   spi_clk  system clock, all logic on posedge
//   spi_rst  synchronous active-high reset (aborts a frame without done)
//   bus      spi_mosi_tx_if.slave: tx_data/tx_valid/tx_ready handshake plus
//            spi_cs, spi_sclk, spi_mosi_out, busy, done (all registered)
// -----------------------------------------------------------------------------
module spi_mosi_tx #(
  parameter int DSIZE     = 8,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic          spi_clk,
  input  logic          spi_rst,
  spi_mosi_tx_if.slave  bus
);

  localparam int BIT_W = $clog2(DSIZE);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DSIZE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 0) ? (CS_GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] data_q,  data_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [GAP_W-1:0] gap_q,   gap_d;
  logic             cs_q,    cs_d;
  logic             sclk_q,  sclk_d;
  logic             mosi_q,  mosi_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             div_tc;

  // Bit of the word sent in slot idx (slot 0 goes out first).
  function automatic logic pick_bit(input logic [DSIZE-1:0] word,
                                    input logic [BIT_W-1:0] idx);
    if (LSB_FIRST != 0) begin
      pick_bit = word[idx];
    end else begin
      pick_bit = word[BIT_LAST - idx];
    end
  endfunction

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_tc  = (div_q == DIV_LAST);

    // The divider only runs while sclk is being generated or trailed.
    if ((state_q == S_LEAD) || (state_q == S_SHIFT) || (state_q == S_TRAIL)) begin
      div_d = div_tc ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
    end else begin
      div_d = div_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid && ready_q) begin
          data_d  = bus.tx_data;
          cs_d    = 1'b0;
          mosi_d  = pick_bit(bus.tx_data, {BIT_W{1'b0}});
          ready_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = {DIV_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
          state_d = S_LEAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD: begin
        if (div_tc) begin
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_LEAD;
        end
      end
      S_SHIFT: begin
        if (div_tc) begin
          sclk_d = ~sclk_q;
          // Data only moves on the falling edge, keeping it stable around each rise.
          if (sclk_q) begin
            if (bit_q == BIT_LAST) begin
              state_d = S_TRAIL;
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              mosi_d = pick_bit(data_q, bit_q + BIT_W'(1));
            end
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_TRAIL: begin
        if (div_tc) begin
          cs_d   = 1'b1;
          mosi_d = 1'b0;
          done_d = 1'b1;
          gap_d  = {GAP_W{1'b0}};
          if (CS_GAP == 0) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_q <= S_IDLE;
      data_q  <= {DSIZE{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_ready     = ready_q;
  assign bus.spi_cs       = cs_q;
  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_mosi_out = mosi_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_spi_mosi_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_mosi_tx
// Three transmitter instances share clock, reset and tx_data:
//   u0: defaults (CLK_DIV=4, CS_GAP=2, LSB first)
//   u1: MSB first, otherwise defaults
//   u2: CLK_DIV=1, CS_GAP=0, LSB first
// A frame observer records, per frame, the bits seen at rising sclk, the
// spi_cs low length, done alignment and the tx_ready return delay; these are
// compared with values from a table and from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_spi_mosi_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       valid_v [3];
  logic       cs_a [3], sclk_a [3], mosi_a [3], ready_a [3], busy_a [3], done_a [3];
  int         sel;
  int         n_vec;
  int         n_bad;

  spi_mosi_tx_if #(.DSIZE(8)) b0 ();
  spi_mosi_tx_if #(.DSIZE(8)) b1 ();
  spi_mosi_tx_if #(.DSIZE(8)) b2 ();

  spi_mosi_tx #(.DSIZE(8), .CLK_DIV(4), .CS_GAP(2), .LSB_FIRST(1)) u0 (
    .spi_clk(clk), .spi_rst(rst), .bus(b0));
  spi_mosi_tx #(.DSIZE(8), .CLK_DIV(4), .CS_GAP(2), .LSB_FIRST(0)) u1 (
    .spi_clk(clk), .spi_rst(rst), .bus(b1));
  spi_mosi_tx #(.DSIZE(8), .CLK_DIV(1), .CS_GAP(0), .LSB_FIRST(1)) u2 (
    .spi_clk(clk), .spi_rst(rst), .bus(b2));

  assign b0.tx_data = tx_data;
  assign b1.tx_data = tx_data;
  assign b2.tx_data = tx_data;
  assign b0.tx_valid = valid_v[0];
  assign b1.tx_valid = valid_v[1];
  assign b2.tx_valid = valid_v[2];

  assign cs_a[0] = b0.spi_cs;        assign cs_a[1] = b1.spi_cs;        assign cs_a[2] = b2.spi_cs;
  assign sclk_a[0] = b0.spi_sclk;    assign sclk_a[1] = b1.spi_sclk;    assign sclk_a[2] = b2.spi_sclk;
  assign mosi_a[0] = b0.spi_mosi_out; assign mosi_a[1] = b1.spi_mosi_out; assign mosi_a[2] = b2.spi_mosi_out;
  assign ready_a[0] = b0.tx_ready;   assign ready_a[1] = b1.tx_ready;   assign ready_a[2] = b2.tx_ready;
  assign busy_a[0] = b0.busy;        assign busy_a[1] = b1.busy;        assign busy_a[2] = b2.busy;
  assign done_a[0] = b0.done;        assign done_a[1] = b1.done;        assign done_a[2] = b2.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-run observations
  logic [7:0] r_bits [2];
  int r_low [2], r_rises [2], r_done_al [2], r_ready_dly [2], rise_c [2];
  int r_high, r_done_total, r_busy_err, r_tail_low, r_timeout;

  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [7:0] exp_s;    // bit k = value seen at k-th rising sclk
    int         exp_low;
    int         exp_dly;
  } vec_t;
  vec_t tbl [3];

  // Configuration of each instance
  function automatic int cfg_div(input int s);
    return (s == 2) ? 1 : 4;
  endfunction
  function automatic int cfg_gap(input int s);
    return (s == 2) ? 0 : 2;
  endfunction
  function automatic bit cfg_lsb(input int s);
    return (s != 1);
  endfunction

  // Reference model: order in which the word's bits appear on the line.
  function automatic logic [7:0] model_samples(input logic [7:0] w, input bit lsb);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) s[k] = lsb ? w[k] : w[7-k];
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive n words (w0 then w1, tx_valid held across frames) into instance s
  // and observe the resulting frames; optionally disturb tx_data/tx_valid mid-frame.
  task automatic run_frames(input int s, input logic [7:0] w0, input logic [7:0] w1,
                            input int n, input bit disturb);
    int c, f, accepted, tail, dist_st;
    logic prev_ready, prev_cs, prev_sclk;
    sel = s;
    c = 0; f = 0; accepted = 0; tail = -1; dist_st = 0;
    r_high = 0; r_done_total = 0; r_busy_err = 0; r_tail_low = 0; r_timeout = 0;
    for (int i = 0; i < 2; i++) begin
      r_bits[i] = 8'h00; r_low[i] = 0; r_rises[i] = 0;
      r_done_al[i] = 0; r_ready_dly[i] = -1; rise_c[i] = 0;
    end
    @(negedge clk);
    prev_ready = ready_a[s]; prev_cs = cs_a[s]; prev_sclk = sclk_a[s];
    tx_data = w0;
    valid_v[s] = 1'b1;
    while (1) begin
      @(negedge clk);
      c++;
      if (dist_st == 1) begin
        valid_v[s] = 1'b0;
        dist_st = 2;
      end
      if (valid_v[s] && prev_ready && !ready_a[s]) begin
        accepted++;
        if (accepted < n) tx_data = w1;
        else valid_v[s] = 1'b0;
      end
      if (!cs_a[s] && f < 2) begin
        r_low[f]++;
        if (sclk_a[s] && !prev_sclk) begin
          if (r_rises[f] < 8) r_bits[f][r_rises[f]] = mosi_a[s];
          r_rises[f]++;
        end
      end
      if (cs_a[s] && !prev_cs && f < 2) begin
        r_done_al[f] = int'(done_a[s]);
        rise_c[f] = c;
        f++;
      end
      if (done_a[s]) r_done_total++;
      if (f > 0 && r_ready_dly[f-1] < 0 && ready_a[s]) r_ready_dly[f-1] = c - rise_c[f-1];
      if (n == 2 && f == 1 && cs_a[s]) r_high++;
      if (busy_a[s] == ready_a[s]) r_busy_err++;
      if (disturb && dist_st == 0 && f == 0 && !cs_a[s] && r_low[0] == 5 && !valid_v[s]) begin
        tx_data = 8'hFF;
        valid_v[s] = 1'b1;
        dist_st = 1;
      end
      if (tail < 0) begin
        if (f == n && r_ready_dly[n-1] >= 0) tail = 0;
      end else begin
        tail++;
        if (!cs_a[s]) r_tail_low++;
        if (tail >= 8) break;
      end
      if (c > 600) begin
        r_timeout = 1;
        break;
      end
      prev_ready = ready_a[s]; prev_cs = cs_a[s]; prev_sclk = sclk_a[s];
    end
    valid_v[s] = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input int exp_low, input int exp_dly,
                           input int exp_high);
    logic [7:0] e;
    check({tag, " timeout"}, r_timeout, 0);
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? e0 : e1;
      check($sformatf("%s f%0d bits", tag, i), int'(r_bits[i]), int'(e));
      check($sformatf("%s f%0d cs_low", tag, i), r_low[i], exp_low);
      check($sformatf("%s f%0d rises", tag, i), r_rises[i], 8);
      check($sformatf("%s f%0d done_at_cs_rise", tag, i), r_done_al[i], 1);
      check($sformatf("%s f%0d ready_dly", tag, i), r_ready_dly[i], exp_dly);
    end
    check({tag, " done_count"}, r_done_total, n);
    check({tag, " busy_vs_ready"}, r_busy_err, 0);
    check({tag, " no_extra_frame"}, r_tail_low, 0);
    if (n == 2) check({tag, " cs_high_between"}, r_high, exp_high);
  endtask

  initial begin
    int rises, c, dn, lowc;
    logic prev_sclk;
    logic [7:0] wa, wb;

    n_vec = 0; n_bad = 0; sel = 0;
    tx_data = 8'h00;
    for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;

    tbl[0] = '{sel: 0, word: 8'hC1, exp_s: 8'hC1, exp_low: 68, exp_dly: 2};
    tbl[1] = '{sel: 1, word: 8'hC1, exp_s: 8'h83, exp_low: 68, exp_dly: 2};
    tbl[2] = '{sel: 2, word: 8'h5A, exp_s: 8'h5A, exp_low: 17, exp_dly: 0};

    // Reset with tx_valid asserted: outputs idle, no handshake taken.
    rst = 1'b1;
    @(negedge clk);
    tx_data = 8'hAA;
    for (int i = 0; i < 3; i++) valid_v[i] = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst u%0d cs", i), int'(cs_a[i]), 1);
        check($sformatf("rst u%0d sclk", i), int'(sclk_a[i]), 0);
        check($sformatf("rst u%0d mosi", i), int'(mosi_a[i]), 0);
        check($sformatf("rst u%0d ready", i), int'(ready_a[i]), 1);
        check($sformatf("rst u%0d busy", i), int'(busy_a[i]), 0);
        check($sformatf("rst u%0d done", i), int'(done_a[i]), 0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("post_rst u%0d cs", i), int'(cs_a[i]), 1);

    // Table-driven single frames (u2 also gets a mid-frame tx_data/tx_valid disturbance).
    for (int t = 0; t < 3; t++) begin
      run_frames(tbl[t].sel, tbl[t].word, 8'h00, 1, tbl[t].sel == 2);
      check_run($sformatf("tbl%0d", t), 1, tbl[t].exp_s, 8'h00, tbl[t].exp_low, tbl[t].exp_dly, 0);
    end

    // Back-to-back with tx_valid held: 8'h3C then 8'h81.
    run_frames(0, 8'h3C, 8'h81, 2, 1'b0);
    check_run("b2b", 2, model_samples(8'h3C, 1'b1), model_samples(8'h81, 1'b1), 68, 2, 3);

    // Reset after the third rising sclk of 8'hFF aborts the frame without done.
    sel = 0;
    @(negedge clk);
    tx_data = 8'hFF;
    valid_v[0] = 1'b1;
    rises = 0; c = 0; prev_sclk = sclk_a[0];
    while (rises < 3 && c < 400) begin
      @(negedge clk);
      c++;
      if (!ready_a[0]) valid_v[0] = 1'b0;
      if (sclk_a[0] && !prev_sclk) rises++;
      prev_sclk = sclk_a[0];
    end
    check("abort reached_3rd_rise", rises, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort cs", int'(cs_a[0]), 1);
    check("abort sclk", int'(sclk_a[0]), 0);
    check("abort mosi", int'(mosi_a[0]), 0);
    check("abort done", int'(done_a[0]), 0);
    check("abort ready", int'(ready_a[0]), 1);
    check("abort busy", int'(busy_a[0]), 0);
    dn = 0; lowc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a[0]) dn++;
      if (!cs_a[0]) lowc++;
    end
    check("abort no_done", dn, 0);
    check("abort cs_stays_high", lowc, 0);
    run_frames(0, 8'h0F, 8'h00, 1, 1'b0);
    check_run("after_abort", 1, model_samples(8'h0F, 1'b1), 8'h00, 68, 2, 0);

    // Randomized frames against the reference model on every configuration.
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 3; r++) begin
        wa = 8'($urandom_range(255, 0));
        run_frames(s, wa, 8'h00, 1, 1'b0);
        check_run($sformatf("rnd u%0d #%0d w=%02h", s, r, wa), 1,
                  model_samples(wa, cfg_lsb(s)), 8'h00,
                  (2 * 8 + 1) * cfg_div(s), cfg_gap(s), 0);
      end
      wa = 8'($urandom_range(255, 0));
      wb = 8'($urandom_range(255, 0));
      run_frames(s, wa, wb, 2, 1'b0);
      check_run($sformatf("rnd_b2b u%0d w=%02h,%02h", s, wa, wb), 2,
                model_samples(wa, cfg_lsb(s)), model_samples(wb, cfg_lsb(s)),
                (2 * 8 + 1) * cfg_div(s), cfg_gap(s), cfg_gap(s) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
